// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 16-bit XNOR-feedback random stream: self-seeds from
// received words, confirms lock, then flywheels and counts mismatches.
module lfsr_stream_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             ivalid,
   input  logic             iready,
   output logic             ovalid,
   output logic             oready,
   input  logic [15:0]      data_in,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       state_dbg
);

   // Handshake: a sample is taken on every rising edge with ivalid=1 (oready is
   // tied high); ovalid pulses one cycle later. iready is not consulted because
   // every status output is a level or a sticky count.

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(LOSS_CNT + 1);
   localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
   localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_CNT - 1);

   state_t          state;
   logic [15:0]     expected;
   logic [GW-1:0]   good_run;
   logic [BW-1:0]   bad_run;
   logic            match;
   logic            all_ones;
   logic            unused_inputs;

   function automatic logic [15:0] nxt(input logic [15:0] s);
      return {s[14], s[13] ~^ s[15], s[12] ~^ s[15], s[11] ~^ s[15], s[10:6],
              s[5] ~^ s[15], s[4] ~^ s[15], s[3] ~^ s[15], s[2:0], s[15]};
   endfunction

   assign match         = (data_in == expected);
   assign all_ones      = (data_in == 16'hFFFF);
   assign oready        = 1'b1;
   assign state_dbg     = state;
   assign unused_inputs = iready;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= HUNT;
         expected     <= 16'h0000;
         good_run     <= '0;
         bad_run      <= '0;
         locked       <= 1'b0;
         err_pulse    <= 1'b0;
         ovalid       <= 1'b0;
         sample_count <= '0;
         err_count    <= '0;
      end else begin
         ovalid    <= ivalid;
         err_pulse <= 1'b0;
         if (ivalid) begin
            case (state)
               HUNT: begin
                  // The lock-up word would predict itself forever, so never seed from it.
                  if (!all_ones) begin
                     expected <= nxt(data_in);
                     good_run <= '0;
                     state    <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (match) begin
                     expected <= nxt(data_in);
                     good_run <= good_run + 1'b1;
                     if (good_run == LOCK_LAST) begin
                        state   <= LOCKED;
                        locked  <= 1'b1;
                        bad_run <= '0;
                     end
                  end else if (all_ones) begin
                     state <= HUNT;
                  end else begin
                     expected <= nxt(data_in);
                     good_run <= '0;
                  end
               end
               LOCKED: begin
                  // Flywheel: the prediction advances from itself, never from the received word.
                  expected <= nxt(expected);
                  if (match) begin
                     bad_run <= '0;
                  end else begin
                     err_pulse <= 1'b1;
                     bad_run   <= bad_run + 1'b1;
                     if (bad_run == LOSS_LAST) begin
                        state  <= HUNT;
                        locked <= 1'b0;
                     end
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end

         if (clear) begin
            sample_count <= '0;
            err_count    <= '0;
         end else if (ivalid && state == LOCKED) begin
            if (sample_count != {CNT_W{1'b1}}) sample_count <= sample_count + 1'b1;
            if (!match && err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: lock, flywheel, loss, gaps, dropped
// words, lock-up word, clear, counter saturation and asynchronous reset.
module tb_lfsr_stream_checker;

   logic        clock = 1'b0;
   logic        resetn;
   logic        ivalid;
   logic        iready;
   logic        clear;
   logic [15:0] data_in;

   logic        ovalid, oready, locked, err_pulse;
   logic [31:0] sample_count, err_count;
   logic [1:0]  state_dbg;

   logic        ovalid4, oready4, locked4, err_pulse4;
   logic [3:0]  sample_count4, err_count4;
   logic [1:0]  state_dbg4;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] w;

   always #5 clock = ~clock;

   lfsr_stream_checker dut (
      .clock(clock), .resetn(resetn), .ivalid(ivalid), .iready(iready),
      .ovalid(ovalid), .oready(oready), .data_in(data_in), .clear(clear),
      .locked(locked), .err_pulse(err_pulse), .sample_count(sample_count),
      .err_count(err_count), .state_dbg(state_dbg)
   );

   lfsr_stream_checker #(.CNT_W(4)) dut4 (
      .clock(clock), .resetn(resetn), .ivalid(ivalid), .iready(iready),
      .ovalid(ovalid4), .oready(oready4), .data_in(data_in), .clear(clear),
      .locked(locked4), .err_pulse(err_pulse4), .sample_count(sample_count4),
      .err_count(err_count4), .state_dbg(state_dbg4)
   );

   function automatic logic [15:0] nxt(input logic [15:0] s);
      logic [15:0] n;
      n[0] = s[15];
      for (int i = 1; i < 16; i++) begin
         if (i == 4 || i == 5 || i == 6 || i == 12 || i == 13 || i == 14)
            n[i] = ~(s[i-1] ^ s[15]);
         else
            n[i] = s[i-1];
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one cycle of inputs, then look at the outputs just after the edge.
   task automatic step(input logic v, input logic [15:0] d, input logic c);
      ivalid  = v;
      data_in = d;
      clear   = c;
      @(posedge clock);
      #1;
      ivalid = 1'b0;
      clear  = 1'b0;
   endtask

   task automatic good();
      step(1'b1, w, 1'b0);
      w = nxt(w);
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      resetn  = 1'b0;
      ivalid  = 1'b0;
      iready  = 1'b0;
      clear   = 1'b0;
      data_in = 16'h0000;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
      chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
      chk("rst_oready", {31'd0, oready}, 32'd1);
      chk("rst_sample_count", sample_count, 32'd0);
      chk("rst_err_count", err_count, 32'd0);
      chk("rst_state", {30'd0, state_dbg}, 32'd0);
      resetn = 1'b1;

      // Lock from 0x0000: locked rises after the fifth sample.
      w = 16'h0000;
      for (int i = 1; i <= 4; i++) begin
         good();
         chk("prelock_locked", {31'd0, locked}, 32'd0);
      end
      good();
      chk("lock0_locked", {31'd0, locked}, 32'd1);
      chk("lock0_ovalid", {31'd0, ovalid}, 32'd1);
      chk("lock0_state", {30'd0, state_dbg}, 32'd2);
      chk("lock0_sample_count", sample_count, 32'd0);
      good();
      good();
      chk("lock0_sc2", sample_count, 32'd2);
      chk("lock0_err", err_count, 32'd0);
      step(1'b0, 16'h1234, 1'b0);
      chk("idle_ovalid", {31'd0, ovalid}, 32'd0);
      chk("idle_sc", sample_count, 32'd2);

      // Asynchronous reset while locked, checked between clock edges.
      #3 resetn = 1'b0;
      #1;
      chk("areset_locked", {31'd0, locked}, 32'd0);
      chk("areset_sc", sample_count, 32'd0);
      chk("areset_state", {30'd0, state_dbg}, 32'd0);
      @(posedge clock);
      #1;
      resetn = 1'b1;

      // Lock from 0x0001, single corrupted word, flywheel recovers.
      w = 16'h0001;
      repeat (5) good();
      chk("lock1_locked", {31'd0, locked}, 32'd1);
      good();
      chk("lock1_sc", sample_count, 32'd1);
      step(1'b1, w ^ 16'h0100, 1'b0);
      w = nxt(w);
      chk("flip_err_pulse", {31'd0, err_pulse}, 32'd1);
      chk("flip_err_count", err_count, 32'd1);
      chk("flip_locked", {31'd0, locked}, 32'd1);
      chk("flip_sc", sample_count, 32'd2);
      good();
      chk("fly_err_pulse", {31'd0, err_pulse}, 32'd0);
      chk("fly_err_count", err_count, 32'd1);
      chk("fly_sc", sample_count, 32'd3);

      // Clear together with a locked sample: that sample is not counted.
      step(1'b1, w, 1'b1);
      w = nxt(w);
      chk("clear_sc", sample_count, 32'd0);
      chk("clear_err", err_count, 32'd0);
      chk("clear_locked", {31'd0, locked}, 32'd1);

      // Three consecutive wrong words lose lock.
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, w ^ 16'h8000, 1'b0);
         w = nxt(w);
         chk("loss_err_count", err_count, 32'(i));
         chk("loss_err_pulse", {31'd0, err_pulse}, 32'd1);
         chk("loss_locked", {31'd0, locked}, {31'd0, (i < 3)});
      end
      chk("loss_sc", sample_count, 32'd3);
      chk("loss_state", {30'd0, state_dbg}, 32'd0);
      good();
      chk("reseed_state", {30'd0, state_dbg}, 32'd1);
      repeat (3) good();
      chk("relock_not_yet", {31'd0, locked}, 32'd0);
      good();
      chk("relock_locked", {31'd0, locked}, 32'd1);
      chk("relock_sc", sample_count, 32'd3);

      // Idle gaps of 1..5 cycles keep lock without errors.
      for (int g = 1; g <= 5; g++) begin
         repeat (g) step(1'b0, 16'hFFFF, 1'b0);
         good();
         chk("gap_err_pulse", {31'd0, err_pulse}, 32'd0);
         chk("gap_locked", {31'd0, locked}, 32'd1);
      end
      chk("gap_sc", sample_count, 32'd8);
      chk("gap_err", err_count, 32'd3);

      // Dropped word: every following word errors until lock is lost.
      w = nxt(w);
      for (int i = 1; i <= 3; i++) begin
         good();
         chk("drop_err_pulse", {31'd0, err_pulse}, 32'd1);
         chk("drop_err_count", err_count, 32'(3 + i));
         chk("drop_locked", {31'd0, locked}, {31'd0, (i < 3)});
      end
      repeat (5) good();
      chk("drop_relock", {31'd0, locked}, 32'd1);
      chk("drop_sc", sample_count, 32'd11);
      chk("drop_err", err_count, 32'd6);

      // Lock-up word never seeds.
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 16'hFFFF, 1'b0);
         chk("ffff_ovalid", {31'd0, ovalid}, 32'd1);
         chk("ffff_state", {30'd0, state_dbg}, 32'd0);
         chk("ffff_locked", {31'd0, locked}, 32'd0);
         chk("ffff_sc", sample_count, 32'd0);
         chk("ffff_err", err_count, 32'd0);
      end
      step(1'b1, 16'h1357, 1'b0);
      chk("seed_state", {30'd0, state_dbg}, 32'd1);
      step(1'b1, 16'hFFFF, 1'b0);
      chk("verify_ffff_state", {30'd0, state_dbg}, 32'd0);

      // Mismatch in VERIFY reseeds from the received word.
      step(1'b1, 16'h1357, 1'b0);
      step(1'b1, 16'h2468, 1'b0);
      chk("verify_reseed_state", {30'd0, state_dbg}, 32'd1);
      w = nxt(16'h2468);
      repeat (3) good();
      chk("reseed_not_locked", {31'd0, locked}, 32'd0);
      good();
      chk("reseed_locked", {31'd0, locked}, 32'd1);

      // Saturation on the 4-bit instance.
      step(1'b0, 16'h0000, 1'b1);
      chk("sat_clear_sc4", {28'd0, sample_count4}, 32'd0);
      repeat (20) good();
      chk("sat_sc4", {28'd0, sample_count4}, 32'hF);
      chk("sat_sc32", sample_count, 32'd20);
      for (int i = 0; i < 17; i++) begin
         step(1'b1, w ^ 16'h0001, 1'b0);
         w = nxt(w);
         good();
      end
      chk("sat_err4", {28'd0, err_count4}, 32'hF);
      chk("sat_err32", err_count, 32'd17);
      chk("sat_sc4_hold", {28'd0, sample_count4}, 32'hF);
      chk("sat_sc32_after", sample_count, 32'd54);
      chk("sat_locked4", {31'd0, locked4}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Receive-side companion to the 16-bit XNOR-feedback random generator. It accepts the generator's 16-bit output stream and self-synchronises by seeding its own predictor from a received word. It then confirms lock and counts mismatches against the predicted sequence. It sits on the consumer side of the OpenCL RTL library boundary and uses the same ivalid/iready/ovalid/oready port set, so the FPGA kernels can check random-stream integrity (stuck bits, dropped or duplicated words) at run time.

## Interface
- LOCK_CNT, 4: consecutive correct predictions in VERIFY required to enter LOCKED (≥1).
- LOSS_CNT, 3: consecutive mismatches in LOCKED that force return to HUNT (≥1).
- CNT_W, 32: width of sample_count and err_count.
- clock  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- ivalid  in  1  data_in valid; a sample is accepted on every rising edge with ivalid=1.
- iready  in  1  downstream ready; ignored, because all status outputs are level/sticky.
- ovalid  out  1  one-cycle pulse, registered, one cycle after each accepted sample.
- oready  out  1  constant 1; the checker accepts a sample every cycle.
- data_in  in  16  received random word.
- clear  in  1  synchronous clear of sample_count and err_count; does not affect the FSM.
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse for each mismatch detected in LOCKED.
- sample_count  out  CNT_W  samples accepted while in LOCKED (saturating).
- err_count  out  CNT_W  mismatches detected in LOCKED (saturating).

## Operation
- Next-state function nxt(s), identical to the generator:
  - nxt[0]=s[15].
  - nxt[i]=s[i-1] for i in 1–3, 7–11 and 15.
  - nxt[i]=s[i-1] XNOR s[15] for i in 4, 5, 6, 12, 13 and 14.
- 16'hFFFF is the lock-up state (nxt(FFFF)=FFFF) and is never used as a seed.
- Internal registers:
  - expected[15:0]
  - good_run, counts up to LOCK_CNT
  - bad_run, counts up to LOSS_CNT
  - 2-bit state
- FSM transitions, acting only on accepted samples (d = data_in):
  - HUNT, d=FFFF: stay in HUNT.
  - HUNT, otherwise: expected←nxt(d), good_run←0, go to VERIFY.
  - VERIFY, d==expected: expected←nxt(d), good_run+1. When good_run+1==LOCK_CNT, go to LOCKED with bad_run←0.
  - VERIFY, d!=expected and d=FFFF: go to HUNT.
  - VERIFY, d!=expected and d!=FFFF: reseed with expected←nxt(d), good_run←0, stay in VERIFY.
  - LOCKED, d==expected: expected←nxt(expected), bad_run←0.
  - LOCKED, d!=expected: flywheel with expected←nxt(expected) (no reseed). err_pulse=1, err_count+1, bad_run+1. When bad_run+1==LOSS_CNT, go to HUNT.
- sample_count increments on every accepted sample while in LOCKED, including errored ones.
- Both counters saturate at all-ones.
- clear coincident with an accepted sample: clear wins and that sample is not counted. FSM and err_pulse behave normally.
- ivalid=0: no state change; err_pulse=0; ovalid=0.

## Timing
- All outputs are registered. A sample accepted at edge k has its effect on locked, err_pulse, the counters and ovalid visible from edge k through edge k+1. Latency is 1 cycle.
- Throughput is one sample per clock, with no bubbles.
- Minimum time to lock from HUNT is LOCK_CNT+1 accepted samples. locked rises after the (LOCK_CNT+1)-th consecutive correct-sequence sample.
- Values after resetn low:
  - state=HUNT
  - expected=0, good_run=0, bad_run=0
  - locked=0, err_pulse=0, ovalid=0
  - sample_count=0, err_count=0
  - oready=1
- Reset mid-stream discards lock immediately. A re-lock needs LOCK_CNT+1 fresh samples.

## Test plan
- After reset, feed 0x0000, 0x7070, nxt(0x7070)… continuously → locked=1 after the 5th sample (LOCK_CNT=4). sample_count counts from the 6th sample onward. err_count=0.
- Locked on a sequence starting at 0x0001 (nxt=0x7072): corrupt one word with a bit flip → one err_pulse, err_count=1, locked stays 1, and the next correct word matches (flywheel, no reseed).
- While locked, feed 3 consecutive wrong words → err_count=3, locked falls after the 3rd. The next valid word reseeds; lock returns after 4 more correct words.
- Feed 0xFFFF repeatedly from HUNT → stays in HUNT, locked=0, counters 0, ovalid pulses once per sample.
- Insert ivalid=0 gaps of 1–5 cycles into a correct stream → no errors and lock is held. Drop one word from the stream → exactly one error per subsequent word until LOSS_CNT is reached, then re-lock.
- Assert clear together with a locked sample → both counters read 0 the next cycle. Force counters near all-ones (CNT_W=4) → they saturate at 0xF. Assert resetn low mid-lock → all outputs return to reset values asynchronously.
